// File: rtl/kmeans_pkg.sv
// Shared constants and types for the k-means engine.
// Holds the PNL BRAM layout, PN clamp limits and loader FSM states.
package kmeans_pkg;

  localparam int PNL_BRAM_ADDR_SIZE_NB   = 15;
  localparam int PNL_BRAM_DBITS_WIDTH_NB = 16;
  localparam int NUM_PNS                 = 4096;

  localparam int NUM_VALS_ADDR     = 0;
  localparam int NUM_CLUSTERS_ADDR = 1;
  localparam int NUM_DIMS_ADDR     = 2;
  localparam int PROG_VALS         = 3;
  localparam int PN_BRAM_BASE      = 24576;

  localparam int LARGEST_POS_VAL = 16383;
  localparam int LARGEST_NEG_VAL = -16383;
  localparam int PN_WORD_BYTES   = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_HI,
    S_CFG_LO,
    S_CFG_WR,
    S_CHECK,
    S_PN_HI,
    S_PN_LO,
    S_PN_WR,
    S_DONE,
    S_ERR
  } loader_state_t;

  typedef struct packed {
    logic [15:0] val;
    logic        clamped;
  } pn_clamp_t;

  // PN words are signed 12.4; saturate symmetrically.
  function automatic pn_clamp_t pn_clamp(input logic [15:0] w);
    pn_clamp_t r;
    int        v;
    v         = int'($signed(w));
    r.val     = w;
    r.clamped = 1'b0;
    if (v > LARGEST_POS_VAL) begin
      r.val     = 16'(LARGEST_POS_VAL);
      r.clamped = 1'b1;
    end else if (v < LARGEST_NEG_VAL) begin
      r.val     = 16'(LARGEST_NEG_VAL);
      r.clamped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/kmeans_pn_loader.sv
// Host byte stream to PNL BRAM writer for the k-means engine.
// Writes the config words, checks them, then the clamped PN words.
module kmeans_pn_loader
  import kmeans_pkg::*;
#(
  parameter int ADDR_NB = PNL_BRAM_ADDR_SIZE_NB,
  parameter int DATA_NB = PNL_BRAM_DBITS_WIDTH_NB,
  parameter int MAX_PNS = NUM_PNS
) (
  input  logic               Clk,
  input  logic               RESET,
  input  logic               start_i,
  input  logic [7:0]         byte_i,
  input  logic               byte_valid_i,
  output logic               byte_ready_o,
  output logic [ADDR_NB-1:0] bram_addr_o,
  output logic [DATA_NB-1:0] bram_din_o,
  output logic               bram_we_o,
  output logic               ready_o,
  output logic               done_o,
  output logic               err_cfg_o,
  output logic               err_range_o,
  output logic [12:0]        word_cnt_o
);

  localparam int WORD_NB = 8 * PN_WORD_BYTES;

  loader_state_t      state_q, state_d;
  logic [7:0]         hi_q, hi_d;
  logic [1:0]         cfg_idx_q, cfg_idx_d;
  logic [WORD_NB-1:0] cfg_q [PROG_VALS];
  logic [WORD_NB-1:0] cfg_d [PROG_VALS];
  logic [12:0]        word_cnt_q, word_cnt_d;
  logic [ADDR_NB-1:0] addr_q, addr_d;
  logic [DATA_NB-1:0] din_q, din_d;
  logic               we_q, we_d;
  logic               done_q, done_d;
  logic               brdy_q, brdy_d;
  logic               idle_q, idle_d;
  logic               err_cfg_q, err_cfg_d;
  logic               err_range_q, err_range_d;

  logic [WORD_NB-1:0] word;
  pn_clamp_t          cl;
  logic [ADDR_NB-1:0] cfg_addr;
  logic               cfg_ok;
  logic               last_pn;

  assign word = {hi_q, byte_i};
  assign cl   = pn_clamp(word);

  always_comb begin
    unique case (cfg_idx_q)
      2'd0:    cfg_addr = ADDR_NB'(NUM_VALS_ADDR);
      2'd1:    cfg_addr = ADDR_NB'(NUM_CLUSTERS_ADDR);
      default: cfg_addr = ADDR_NB'(NUM_DIMS_ADDR);
    endcase
  end

  // Bounding num_vals here keeps every PN address inside the PN region.
  assign cfg_ok = (cfg_q[0] != '0)
               && (cfg_q[0] <= 16'(MAX_PNS))
               && (cfg_q[2] != '0);

  assign last_pn = (16'(word_cnt_q) + 16'd1) == cfg_q[0];

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    cfg_idx_d   = cfg_idx_q;
    cfg_d       = cfg_q;
    word_cnt_d  = word_cnt_q;
    addr_d      = addr_q;
    din_d       = din_q;
    we_d        = 1'b0;
    err_cfg_d   = err_cfg_q;
    err_range_d = err_range_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_cfg_d   = 1'b0;
          err_range_d = 1'b0;
          word_cnt_d  = '0;
          cfg_idx_d   = '0;
          state_d     = S_CFG_HI;
        end
      end
      S_CFG_HI: begin
        if (byte_valid_i) begin
          hi_d    = byte_i;
          state_d = S_CFG_LO;
        end
      end
      S_CFG_LO: begin
        if (byte_valid_i) begin
          cfg_d[cfg_idx_q] = word;
          addr_d           = cfg_addr;
          din_d            = DATA_NB'(word);
          we_d             = 1'b1;
          state_d          = S_CFG_WR;
        end
      end
      S_CFG_WR: begin
        cfg_idx_d = cfg_idx_q + 2'd1;
        if (cfg_idx_q == 2'(PROG_VALS - 1))
          state_d = S_CHECK;
        else
          state_d = S_CFG_HI;
      end
      S_CHECK: begin
        if (cfg_ok) begin
          state_d = S_PN_HI;
        end else begin
          err_cfg_d = 1'b1;
          state_d   = S_ERR;
        end
      end
      S_PN_HI: begin
        if (byte_valid_i) begin
          hi_d    = byte_i;
          state_d = S_PN_LO;
        end
      end
      S_PN_LO: begin
        if (byte_valid_i) begin
          addr_d      = ADDR_NB'(PN_BRAM_BASE)
                      + ADDR_NB'(word_cnt_q);
          din_d       = DATA_NB'(cl.val);
          err_range_d = err_range_q | cl.clamped;
          we_d        = 1'b1;
          state_d     = S_PN_WR;
        end
      end
      S_PN_WR: begin
        word_cnt_d = word_cnt_q + 13'd1;
        state_d    = last_pn ? S_DONE : S_PN_HI;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    brdy_d = (state_d == S_CFG_HI) || (state_d == S_CFG_LO)
          || (state_d == S_PN_HI)  || (state_d == S_PN_LO);
    idle_d = (state_d == S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      hi_q        <= '0;
      cfg_idx_q   <= '0;
      for (int i = 0; i < PROG_VALS; i++)
        cfg_q[i] <= '0;
      word_cnt_q  <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      brdy_q      <= 1'b0;
      idle_q      <= 1'b1;
      err_cfg_q   <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      cfg_idx_q   <= cfg_idx_d;
      cfg_q       <= cfg_d;
      word_cnt_q  <= word_cnt_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      we_q        <= we_d;
      done_q      <= done_d;
      brdy_q      <= brdy_d;
      idle_q      <= idle_d;
      err_cfg_q   <= err_cfg_d;
      err_range_q <= err_range_d;
    end
  end

  assign byte_ready_o = brdy_q;
  assign bram_addr_o  = addr_q;
  assign bram_din_o   = din_q;
  assign bram_we_o    = we_q;
  assign ready_o      = idle_q;
  assign done_o       = done_q;
  assign err_cfg_o    = err_cfg_q;
  assign err_range_o  = err_range_q;
  assign word_cnt_o   = word_cnt_q;

endmodule
